// File: rtl/spw_rx_pkg.sv
// spw_rx_pkg: shared decoder states, control codes and NULL hunt pattern.
package spw_rx_pkg;
  typedef enum logic [2:0] {HUNT, HDR, CTRL, DATA, ESC_NXT, ERR} state_t;
  // Control payloads written as {first arrived bit, second arrived bit}
  localparam logic [1:0] C_FCT = 2'b00;
  localparam logic [1:0] C_EOP = 2'b10;
  localparam logic [1:0] C_EEP = 2'b01;
  localparam logic [1:0] C_ESC = 2'b11;
  localparam logic [8:0] EOP_CODE = 9'h100;
  localparam logic [8:0] EEP_CODE = 9'h101;
  localparam logic [6:0] NULL_PAT = 7'b1110100;
endpackage

// File: rtl/spw_rx_fifo.sv
// spw_rx_fifo: first-word-fall-through character FIFO with synchronous flush.
module spw_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             CLK_RX,
  input  logic             RESETn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  assign do_pop = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge CLK_RX or negedge RESETn)
    if (!RESETn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + {{AW{1'b0}}, do_push};
      rd_q <= rd_q + {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge CLK_RX)
    if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/spw_rx_decoder_p.sv
// spw_rx_decoder_p: SpaceWire receive decoder -- NULL hunt, parity and escape
// checking, time-codes, disconnect detection and a buffered character output.
module spw_rx_decoder_p
  import spw_rx_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int ERR_CNT_W    = 8,
  parameter int DISC_TIMEOUT = 64,
  parameter int TC_STRICT    = 1
) (
  input  logic                 CLK_RX,
  input  logic                 RESETn,
  input  logic                 enableRx,
  input  logic                 bit_in,
  input  logic                 bit_vld,
  output logic [8:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 gotNULL,
  output logic                 gotFCT,
  output logic                 gotNChar,
  output logic                 gotTimeCode,
  output logic [7:0]           time_out,
  output logic                 tick_out,
  output logic                 rxError,
  output logic                 disc_err,
  output logic [ERR_CNT_W-1:0] par_err_cnt,
  output logic [ERR_CNT_W-1:0] esc_err_cnt,
  output logic                 overflow,
  input  logic                 clr_cnt
);
  localparam int DW = $clog2(DISC_TIMEOUT + 1);
  localparam logic [DW-1:0] DT = DW'(DISC_TIMEOUT);
  state_t state_q, state_d;
  logic [7:0] sr_q, sr_d, tc_q, tc_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DW-1:0] disc_q, disc_d;
  logic [ERR_CNT_W-1:0] par_cnt_q, par_cnt_d, esc_cnt_q, esc_cnt_d;
  logic par_q, par_d, flag_q, flag_d, pkt_q, pkt_d, null_q, null_d, seen_q, seen_d;
  logic fct_q, fct_d, nchar_q, nchar_d, tcp_q, tcp_d, tick_q, tick_d;
  logic derr_q, derr_d, ovf_q, ovf_d;
  logic [6:0] hunt;
  logic [1:0] code;
  logic [8:0] push_data;
  logic push, drop, par_err, esc_err, disc_hit, fifo_full, fifo_empty;

  spw_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
    .CLK_RX  (CLK_RX),
    .RESETn  (RESETn),
    .flush_i (!enableRx),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (rx_ready),
    .data_o  (rx_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    par_d = par_q;
    flag_d = flag_q;
    pkt_d = pkt_q;
    tc_d = tc_q;
    null_d = null_q;
    fct_d = 1'b0;
    nchar_d = 1'b0;
    tcp_d = 1'b0;
    tick_d = 1'b0;
    seen_d = seen_q | bit_vld;
    disc_d = bit_vld ? '0 : (seen_q && disc_q != DT) ? disc_q + 1'b1 : disc_q;
    disc_hit = seen_q && !bit_vld && disc_q == DT - 1'b1;
    hunt = {sr_q[5:0], bit_in};
    code = {sr_q[7], bit_in};
    push = 1'b0;
    push_data = EOP_CODE;
    par_err = 1'b0;
    esc_err = 1'b0;
    if (bit_vld) begin
      cnt_d = cnt_q + 1'b1;
      sr_d = {bit_in, sr_q[7:1]};
      par_d = par_q ^ bit_in;
      case (state_q)
        HUNT: begin
          sr_d = {1'b0, hunt};
          if (hunt == NULL_PAT) begin
            null_d = 1'b1;
            par_d = 1'b0;
            cnt_d = '0;
            state_d = HDR;
          end
        end
        HDR: if (cnt_q[0]) begin
          cnt_d = '0;
          par_d = 1'b0;
          par_err = !(par_q ^ bit_in);
          state_d = bit_in ? CTRL : DATA;
        end
        CTRL: if (cnt_q[0]) begin
          cnt_d = '0;
          state_d = code == C_ESC ? ESC_NXT : HDR;
          fct_d = code == C_FCT;
          push = code == C_EOP || code == C_EEP;
          nchar_d = push;
          push_data = code == C_EOP ? EOP_CODE : EEP_CODE;
          pkt_d = push ? 1'b0 : pkt_q;
        end
        DATA: if (cnt_q == 4'd7) begin
          cnt_d = '0;
          state_d = HDR;
          push = 1'b1;
          push_data = {1'b0, sr_d};
          nchar_d = 1'b1;
          pkt_d = 1'b1;
        end
        ESC_NXT: begin
          // cnt 0..1 is the escaped character's header, payload follows from cnt 2
          if (cnt_q == 4'd1) begin
            par_d = 1'b0;
            flag_d = bit_in;
            par_err = !(par_q ^ bit_in);
          end
          if (cnt_q == 4'd3 && flag_q) begin
            cnt_d = '0;
            state_d = HDR;
            esc_err = code != C_FCT;
          end
          if (cnt_q == 4'd9) begin
            cnt_d = '0;
            state_d = HDR;
            tc_d = sr_d;
            tcp_d = 1'b1;
            tick_d = TC_STRICT == 0 || sr_d[5:0] == tc_q[5:0] + 6'd1;
          end
        end
        default: ;
      endcase
    end
    if (par_err || esc_err || disc_hit) begin
      state_d = ERR;
      push = pkt_q;
      push_data = EEP_CODE;
      pkt_d = 1'b0;
    end
    if (!enableRx) begin
      state_d = HUNT;
      sr_d = '0;
      cnt_d = '0;
      par_d = 1'b0;
      flag_d = 1'b0;
      pkt_d = 1'b0;
      tc_d = tc_q;
      null_d = 1'b0;
      fct_d = 1'b0;
      nchar_d = 1'b0;
      tcp_d = 1'b0;
      tick_d = 1'b0;
      seen_d = 1'b0;
      disc_d = '0;
      push = 1'b0;
      par_err = 1'b0;
      esc_err = 1'b0;
      disc_hit = 1'b0;
    end
    drop = push && fifo_full && !(rx_ready && !fifo_empty);
    par_cnt_d = clr_cnt ? '0 : par_cnt_q + ERR_CNT_W'(par_err && !(&par_cnt_q));
    esc_cnt_d = clr_cnt ? '0 : esc_cnt_q + ERR_CNT_W'(esc_err && !(&esc_cnt_q));
    derr_d = !clr_cnt && (derr_q || disc_hit);
    ovf_d = !clr_cnt && (ovf_q || drop);
  end

  always_ff @(posedge CLK_RX or negedge RESETn)
    if (!RESETn) begin
      state_q <= HUNT;
      sr_q <= '0;
      tc_q <= '0;
      cnt_q <= '0;
      disc_q <= '0;
      par_cnt_q <= '0;
      esc_cnt_q <= '0;
      par_q <= 1'b0;
      flag_q <= 1'b0;
      pkt_q <= 1'b0;
      null_q <= 1'b0;
      seen_q <= 1'b0;
      fct_q <= 1'b0;
      nchar_q <= 1'b0;
      tcp_q <= 1'b0;
      tick_q <= 1'b0;
      derr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      tc_q <= tc_d;
      cnt_q <= cnt_d;
      disc_q <= disc_d;
      par_cnt_q <= par_cnt_d;
      esc_cnt_q <= esc_cnt_d;
      par_q <= par_d;
      flag_q <= flag_d;
      pkt_q <= pkt_d;
      null_q <= null_d;
      seen_q <= seen_d;
      fct_q <= fct_d;
      nchar_q <= nchar_d;
      tcp_q <= tcp_d;
      tick_q <= tick_d;
      derr_q <= derr_d;
      ovf_q <= ovf_d;
    end

  assign rx_valid = !fifo_empty;
  assign gotNULL = null_q;
  assign gotFCT = fct_q;
  assign gotNChar = nchar_q;
  assign gotTimeCode = tcp_q;
  assign time_out = tc_q;
  assign tick_out = tick_q;
  assign rxError = state_q == ERR;
  assign disc_err = derr_q;
  assign par_err_cnt = par_cnt_q;
  assign esc_err_cnt = esc_cnt_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_spw_rx_decoder_p.sv
// tb_spw_rx_decoder_p: directed vector table plus hand-written error, overflow,
// disconnect and reset sequences for the SpaceWire receive decoder.
module tb_spw_rx_decoder_p;
  logic CLK_RX = 1'b0, RESETn = 1'b0, enableRx = 1'b0, bit_in = 1'b0, bit_vld = 1'b0;
  logic rx_ready = 1'b0, clr_cnt = 1'b0;
  logic [8:0] rx_data;
  logic [7:0] time_out, par_err_cnt, esc_err_cnt;
  logic rx_valid, gotNULL, gotFCT, gotNChar, gotTimeCode, tick_out, rxError, disc_err, overflow;
  int n_cmp = 0, n_err = 0;
  logic ppar = 1'b0;

  always #5 CLK_RX = ~CLK_RX;

  spw_rx_decoder_p #(.FIFO_DEPTH(4), .ERR_CNT_W(8), .DISC_TIMEOUT(64), .TC_STRICT(1)) dut (
    .CLK_RX(CLK_RX), .RESETn(RESETn), .enableRx(enableRx), .bit_in(bit_in), .bit_vld(bit_vld),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .gotNULL(gotNULL),
    .gotFCT(gotFCT), .gotNChar(gotNChar), .gotTimeCode(gotTimeCode), .time_out(time_out),
    .tick_out(tick_out), .rxError(rxError), .disc_err(disc_err), .par_err_cnt(par_err_cnt),
    .esc_err_cnt(esc_err_cnt), .overflow(overflow), .clr_cnt(clr_cnt)
  );

  typedef enum {K_DATA, K_EOP, K_EEP, K_FCT, K_TC, K_NULL} kind_t;
  typedef struct {
    kind_t kind;
    logic [7:0] val;
    logic nchar, fct, tcp, tick;
    logic [7:0] tout;
    logic push;
    logic [8:0] data;
  } vec_t;
  vec_t v [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge CLK_RX);
    bit_in = b;
    bit_vld = 1'b1;
  endtask

  // Header parity makes previous payload + parity + flag odd; bad flips it
  task automatic send_char(input logic flag, input logic [7:0] pl, input int n, input logic bad);
    send_bit(1'b1 ^ ppar ^ flag ^ bad);
    send_bit(flag);
    ppar = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_bit(pl[i]);
      ppar = ppar ^ pl[i];
    end
  endtask

  task automatic ctrl(input logic [7:0] c);
    send_char(1'b1, c, 2, 1'b0);
  endtask

  task automatic send_null();
    ctrl(8'h03);
    ctrl(8'h00);
  endtask

  task automatic settle();
    @(negedge CLK_RX);
    bit_vld = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [8:0] exp);
    chk({name, "_valid"}, 32'(rx_valid), 32'd1);
    chk(name, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge CLK_RX);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_enable_low();
    @(negedge CLK_RX);
    enableRx = 1'b0;
    @(negedge CLK_RX);
    enableRx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    v[0]  = '{K_DATA, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 9'h0A5};
    v[1]  = '{K_EOP,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 9'h100};
    v[2]  = '{K_FCT,  8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 9'h000};
    v[3]  = '{K_TC,   8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 9'h000};
    v[4]  = '{K_TC,   8'h06, 1'b0, 1'b0, 1'b1, 1'b1, 8'h06, 1'b0, 9'h000};
    v[5]  = '{K_DATA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h06, 1'b1, 9'h000};
    v[6]  = '{K_DATA, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h06, 1'b1, 9'h0FF};
    v[7]  = '{K_EEP,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h06, 1'b1, 9'h101};
    v[8]  = '{K_TC,   8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 9'h000};
    v[9]  = '{K_NULL, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 9'h000};
    v[10] = '{K_TC,   8'h09, 1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 1'b0, 9'h000};
    repeat (2) @(negedge CLK_RX);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_time_out", 32'(time_out), 0);
    chk("rst_gotNULL", 32'(gotNULL), 0);
    chk("rst_rxError", 32'(rxError), 0);
    chk("rst_par_cnt", 32'(par_err_cnt), 0);
    RESETn = 1'b1;
    enableRx = 1'b1;
    send_null();
    settle();
    chk("null_gotNULL", 32'(gotNULL), 1);
    for (int i = 0; i < 11; i++) begin
      case (v[i].kind)
        K_DATA: send_char(1'b0, v[i].val, 8, 1'b0);
        K_EOP: ctrl(8'h01);
        K_EEP: ctrl(8'h02);
        K_FCT: ctrl(8'h00);
        K_TC: begin
          ctrl(8'h03);
          send_char(1'b0, v[i].val, 8, 1'b0);
        end
        default: send_null();
      endcase
      settle();
      chk($sformatf("v%0d_nchar", i), 32'(gotNChar), 32'(v[i].nchar));
      chk($sformatf("v%0d_fct", i), 32'(gotFCT), 32'(v[i].fct));
      chk($sformatf("v%0d_tc", i), 32'(gotTimeCode), 32'(v[i].tcp));
      chk($sformatf("v%0d_tick", i), 32'(tick_out), 32'(v[i].tick));
      chk($sformatf("v%0d_time", i), 32'(time_out), 32'(v[i].tout));
      if (v[i].push) pop_chk($sformatf("v%0d_data", i), v[i].data);
      else chk($sformatf("v%0d_empty", i), 32'(rx_valid), 0);
    end
    send_char(1'b0, 8'h3C, 8, 1'b0);
    settle();
    chk("par_nchar", 32'(gotNChar), 1);
    send_char(1'b0, 8'h00, 0, 1'b1);
    settle();
    chk("par_cnt", 32'(par_err_cnt), 1);
    chk("par_rxError", 32'(rxError), 1);
    pop_chk("par_d0", 9'h03C);
    pop_chk("par_d1", 9'h101);
    chk("par_empty", 32'(rx_valid), 0);
    @(negedge CLK_RX);
    enableRx = 1'b0;
    @(negedge CLK_RX);
    chk("dis_rxError", 32'(rxError), 0);
    chk("dis_gotNULL", 32'(gotNULL), 0);
    chk("dis_par_cnt", 32'(par_err_cnt), 1);
    enableRx = 1'b1;
    send_null();
    ctrl(8'h03);
    ctrl(8'h01);
    settle();
    chk("esc_cnt", 32'(esc_err_cnt), 1);
    chk("esc_rxError", 32'(rxError), 1);
    chk("esc_empty", 32'(rx_valid), 0);
    chk("esc_nchar", 32'(gotNChar), 0);
    pulse_enable_low();
    send_null();
    for (int i = 1; i <= 5; i++) send_char(1'b0, 8'(i * 8'h11), 8, 1'b0);
    settle();
    chk("ovf_flag", 32'(overflow), 1);
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("ovf_d%0d", i), 9'(i * 9'h11));
    chk("ovf_empty", 32'(rx_valid), 0);
    chk("disc_early", 32'(disc_err), 0);
    repeat (70) @(negedge CLK_RX);
    chk("disc_err", 32'(disc_err), 1);
    chk("disc_rxError", 32'(rxError), 1);
    pop_chk("disc_eep", 9'h101);
    chk("keep_par_cnt", 32'(par_err_cnt), 1);
    chk("keep_esc_cnt", 32'(esc_err_cnt), 1);
    @(negedge CLK_RX);
    clr_cnt = 1'b1;
    @(negedge CLK_RX);
    clr_cnt = 1'b0;
    chk("clr_par_cnt", 32'(par_err_cnt), 0);
    chk("clr_esc_cnt", 32'(esc_err_cnt), 0);
    chk("clr_disc", 32'(disc_err), 0);
    chk("clr_ovf", 32'(overflow), 0);
    pulse_enable_low();
    send_null();
    send_char(1'b0, 8'h77, 8, 1'b0);
    send_bit(1'b1);
    #3 RESETn = 1'b0;
    #1;
    chk("arst_gotNULL", 32'(gotNULL), 0);
    chk("arst_time_out", 32'(time_out), 0);
    chk("arst_rx_valid", 32'(rx_valid), 0);
    chk("arst_rx_data", 32'(rx_data), 0);
    chk("arst_nchar", 32'(gotNChar), 0);
    bit_vld = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spw_rx_decoder_p.md
SPW_RX_DECODER_P -- requirements
Module: spw_rx_decoder_p

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output character FIFO depth, power of 2, >=2.
REQ-002 Parameter ERR_CNT_W, default 8, width of each saturating error counter.
REQ-003 Parameter DISC_TIMEOUT, default 64, CLK_RX cycles without bit_vld that declare disconnect.
REQ-004 Parameter TC_STRICT, default 1, 1 = tick only on time-code increment, 0 = tick on every valid time-code.
REQ-005 CLK_RX  in  1  receive clock; RESETn  in  1  reset, asynchronous, active-low.
REQ-006 enableRx  in  1  receiver enable; low = synchronous clear of decoder state.
REQ-007 bit_in  in  1  recovered serial bit; bit_vld  in  1  bit_in valid strobe, one cycle per bit.
REQ-008 rx_data  out  9  FIFO head: {flag, byte}; 9'h100 = EOP, 9'h101 = EEP.
REQ-009 rx_valid  out  1  FIFO non-empty; rx_ready  in  1  consumer pop strobe.
REQ-010 gotNULL  out  1  sticky, first NULL detected; gotFCT  out  1  one-cycle pulse per valid FCT.
REQ-011 gotNChar  out  1  one-cycle pulse per valid data/EOP/EEP; gotTimeCode  out  1  one-cycle pulse per valid time-code.
REQ-012 time_out  out  8  last time-code value; tick_out  out  1  one-cycle tick pulse.
REQ-013 rxError  out  1  level, decoder in ERR state; disc_err  out  1  sticky disconnect flag.
REQ-014 par_err_cnt, esc_err_cnt  out  ERR_CNT_W  saturating error counters; overflow  out  1  sticky FIFO-full drop flag; clr_cnt  in  1  clears counters, disc_err, overflow.

Function
REQ-015 Bit order on wire: parity, flag, then payload LSB first; control payload 2 bits (FCT 00, EOP 10, EEP 01, ESC 11 in arrival order), data payload 8 bits.
REQ-016 States: HUNT, HDR, CTRL, DATA, ESC_NXT, ERR; all advance only on bit_vld.
REQ-017 HUNT: shift bits; when last 7 received bits in arrival order equal 1,1,1,0,1,0,0 set gotNULL, load parity accumulator, go HDR.
REQ-018 HDR: after 2 bits (parity, flag) check odd parity over previous payload + this parity + this flag; mismatch -> ERR, par_err_cnt+1; else flag=1 -> CTRL, flag=0 -> DATA.
REQ-019 CTRL: after 2 bits; ESC -> ESC_NXT; FCT -> gotFCT; EOP/EEP -> push code, gotNChar; then HDR.
REQ-020 DATA: after 8 bits push {1'b0, byte}, gotNChar, -> HDR.
REQ-021 ESC_NXT: collect next character; FCT -> NULL (no output) -> HDR; data -> time-code: time_out updated, gotTimeCode pulse -> HDR; ESC/EOP/EEP -> ERR, esc_err_cnt+1.
REQ-022 Output pulses and FIFO push occur in the cycle after the bit_vld of the character's last payload bit.
REQ-023 tick_out pulses with gotTimeCode when TC_STRICT=0 or new time_out[5:0] == (previous[5:0]+1) mod 64; previous value retained internally.
REQ-024 Disconnect: after first bit_vld, DISC_TIMEOUT consecutive cycles without bit_vld -> ERR, disc_err set; counter resets on every bit_vld.
REQ-025 Entering ERR from a packet in progress (data pushed since last EOP/EEP) pushes 9'h101 once; ERR holds until enableRx low.
REQ-026 FIFO: push when not full; push while full drops the character and sets overflow; simultaneous push and pop when full succeeds.
REQ-027 Counters saturate at all-ones; clr_cnt has priority over simultaneous increment.
REQ-028 enableRx low: state -> HUNT, gotNULL, FIFO, pulses, parity and timeout cleared; counters, disc_err, overflow retained.

Reset
REQ-029 RESETn low: all outputs 0, time_out 8'h00, FIFO empty, counters 0, state HUNT, regardless of operation in progress.

Structure
REQ-030 Package spw_rx_pkg holds state enum, control codes, EOP_CODE 9'h100, EEP_CODE 9'h101, NULL hunt pattern.
REQ-031 FIFO is sub-module spw_rx_fifo (parameter DEPTH, WIDTH 9), instantiated once.

Verification
REQ-032 NULL, data 8'hA5, EOP -> rx_data 9'h0A5 then 9'h100, two gotNChar pulses.
REQ-033 NULL, time-codes 8'h05 then 8'h06 (TC_STRICT=1) -> time_out 8'h06, tick_out only on second.
REQ-034 NULL, data 8'h3C, corrupted next parity -> par_err_cnt 1, rxError high, FIFO holds 9'h03C, 9'h101.
REQ-035 NULL, ESC followed by EOP -> esc_err_cnt 1, rxError high, no push (no packet open).
REQ-036 FIFO_DEPTH=4, rx_ready low, 5 data chars -> 4 stored, overflow 1; 70 idle cycles -> disc_err 1.
